// File: rtl/qa_drv_tester_pkg.sv
// Shared types, message layout and LFSR step for the multi-channel driver tester.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package qa_drv_tester_pkg;

  // Encoding of cmd_mode as seen on the command port.
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_SINK     = 2'd1,
    MODE_SOURCE   = 2'd2,
    MODE_LOOPBACK = 2'd3
  } t_TESTER_MODE;

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_SINK,
    ST_SOURCE,
    ST_LOOPBACK,
    ST_SINK_CMPL
  } t_TESTER_STATE;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Test message layout (low 64 bits; LFSR pattern repeats above bit 63).
  localparam int MSG_LAST_BIT = 0;
  localparam int MSG_CNT_LSB  = 1;
  localparam int MSG_CNT_MSB  = 31;
  localparam int MSG_LFSR_LSB = 32;
  localparam int MSG_LFSR_MSB = 63;
  localparam int MSG_ERR_LSB  = 32;
  localparam int MSG_ERR_MSB  = 47;

  // Galois right-shift step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/qa_drv_tester_chan.sv
// One tester channel: NORMAL pass-through, or SINK/SOURCE/LOOPBACK test with LFSR payload and stats.
// Latency: datapath fully combinational; state/stats update on the edge after a beat.
// Backpressure: beats need rdy && enable; client side sees rdy = 0 while a test runs.
// Ports: cmd_load/cmd_mode/cmd_count load a test; rx_fifo_*/tx_fifo_* face the client,
//        rx_*/tx_* face the driver; test_active/test_done/stat_* report progress.
module qa_drv_tester_chan
  import qa_drv_tester_pkg::*;
#(
  parameter int          UMF_WIDTH = 128,
  parameter int          COUNT_W   = 31,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_load,
  input  t_TESTER_MODE         cmd_mode,
  input  logic [COUNT_W-1:0]   cmd_count,
  input  logic                 user_en,
  output logic [UMF_WIDTH-1:0] rx_fifo_data,
  output logic                 rx_fifo_rdy,
  input  logic                 rx_fifo_enable,
  input  logic [UMF_WIDTH-1:0] tx_fifo_data,
  output logic                 tx_fifo_rdy,
  input  logic                 tx_fifo_enable,
  input  logic [UMF_WIDTH-1:0] rx_data,
  input  logic                 rx_rdy,
  output logic                 rx_enable,
  output logic [UMF_WIDTH-1:0] tx_data,
  input  logic                 tx_rdy,
  output logic                 tx_enable,
  output logic                 test_active,
  output logic                 test_done,
  output logic [31:0]          stat_beats,
  output logic [15:0]          stat_errors,
  output logic [31:0]          stat_cycles
);

  t_TESTER_STATE      state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        beats_q, beats_d;
  logic [15:0]        errors_q, errors_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               done_q, done_d;

  logic [UMF_WIDTH-1:0] src_msg;
  logic [UMF_WIDTH-1:0] cmpl_msg;
  logic [30:0]          cnt31;

  assign cnt31 = 31'(count_q);

  // SOURCE payload: last flag, remaining count, LFSR repeated over the upper field.
  always_comb begin
    src_msg = '0;
    for (int j = MSG_LFSR_LSB; j < UMF_WIDTH; j++) begin
      src_msg[j] = lfsr_q[j % 32];
    end
    src_msg[MSG_CNT_MSB:MSG_CNT_LSB] = cnt31;
    src_msg[MSG_LAST_BIT]            = (count_q == COUNT_W'(1));
  end

  // SINK completion report; bit0 forced so the receiver sees it as a last beat.
  always_comb begin
    cmpl_msg                          = '0;
    cmpl_msg[MSG_ERR_MSB:MSG_ERR_LSB] = errors_q;
    cmpl_msg[31:0]                    = beats_q | 32'h1;
  end

  always_comb begin
    rx_fifo_data = rx_data;
    rx_fifo_rdy  = rx_rdy;
    rx_enable    = rx_fifo_enable;
    tx_data      = tx_fifo_data;
    tx_enable    = tx_fifo_enable;
    tx_fifo_rdy  = tx_rdy & user_en;
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    count_d      = count_q;
    beats_d      = beats_q;
    errors_d     = errors_q;
    cycles_d     = cycles_q;
    done_d       = 1'b0;

    if (state_q != ST_NORMAL) begin
      rx_fifo_rdy = 1'b0;
      tx_fifo_rdy = 1'b0;
      rx_enable   = 1'b0;
      tx_enable   = 1'b0;
      if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
    end

    case (state_q)
      ST_SOURCE: begin
        rx_enable = rx_rdy;
        tx_data   = src_msg;
        // A zero count must not emit a beat even with tx_rdy high.
        tx_enable = tx_rdy & (count_q != '0);
        if (count_q == '0) begin
          state_d = ST_NORMAL;
          done_d  = 1'b1;
        end else if (tx_enable) begin
          count_d = count_q - COUNT_W'(1);
          beats_d = beats_q + 32'd1;
          lfsr_d  = lfsr_next(lfsr_q);
          if (count_q == COUNT_W'(1)) begin
            state_d = ST_NORMAL;
            done_d  = 1'b1;
          end
        end
      end
      ST_SINK: begin
        rx_enable = rx_rdy;
        if (rx_rdy) begin
          beats_d = beats_q + 32'd1;
          lfsr_d  = lfsr_next(lfsr_q);
          if (rx_data[MSG_LFSR_MSB:MSG_LFSR_LSB] != lfsr_q && errors_q != '1) begin
            errors_d = errors_q + 16'd1;
          end
          if (rx_data[MSG_LAST_BIT]) state_d = ST_SINK_CMPL;
        end
      end
      ST_SINK_CMPL: begin
        tx_data   = cmpl_msg;
        tx_enable = tx_rdy;
        if (tx_rdy) begin
          state_d = ST_NORMAL;
          done_d  = 1'b1;
        end
      end
      ST_LOOPBACK: begin
        rx_enable = rx_rdy & tx_rdy;
        tx_enable = rx_rdy & tx_rdy;
        tx_data   = rx_data;
        if (rx_rdy && tx_rdy) begin
          beats_d = beats_q + 32'd1;
          lfsr_d  = lfsr_next(lfsr_q);
          if (rx_data[MSG_LAST_BIT]) begin
            state_d = ST_NORMAL;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A command overrides whatever the test was doing this cycle, including completion.
    if (cmd_load) begin
      case (cmd_mode)
        MODE_SINK:     state_d = ST_SINK;
        MODE_SOURCE:   state_d = ST_SOURCE;
        MODE_LOOPBACK: state_d = ST_LOOPBACK;
        default:       state_d = ST_NORMAL;
      endcase
      lfsr_d   = SEED;
      count_d  = cmd_count;
      beats_d  = '0;
      errors_d = '0;
      cycles_d = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      lfsr_q   <= SEED;
      count_q  <= '0;
      beats_q  <= '0;
      errors_q <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      beats_q  <= beats_d;
      errors_q <= errors_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
    end
  end

  assign test_active = (state_q != ST_NORMAL);
  assign test_done   = done_q;
  assign stat_beats  = beats_q;
  assign stat_errors = errors_q;
  assign stat_cycles = cycles_q;

endmodule

// File: rtl/qa_drv_tester_mc.sv
// Multi-channel driver tester: decodes per-channel commands and replicates the channel tester.
// Latency: zero-cycle datapath per channel; commands take effect on the next edge.
// Backpressure: per channel, rdy/enable handshake on both driver and client sides.
// Ports: cmd_* select channel and mode; all other buses are N_CHAN slices packed LSB-first
//        (channel i at [i*W +: W]).
module qa_drv_tester_mc
  import qa_drv_tester_pkg::*;
#(
  parameter int          UMF_WIDTH  = 128,
  parameter int          N_CHAN     = 2,
  parameter int          COUNT_W    = 31,
  parameter logic [31:0] LFSR_SEED  = 32'h1,
  localparam int         CHAN_IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [CHAN_IDX_W-1:0]         cmd_chan,
  input  logic [1:0]                    cmd_mode,
  input  logic [COUNT_W-1:0]            cmd_count,
  input  logic [N_CHAN-1:0]             user_en,
  output logic [N_CHAN*UMF_WIDTH-1:0]   rx_fifo_data,
  output logic [N_CHAN-1:0]             rx_fifo_rdy,
  input  logic [N_CHAN-1:0]             rx_fifo_enable,
  input  logic [N_CHAN*UMF_WIDTH-1:0]   tx_fifo_data,
  output logic [N_CHAN-1:0]             tx_fifo_rdy,
  input  logic [N_CHAN-1:0]             tx_fifo_enable,
  input  logic [N_CHAN*UMF_WIDTH-1:0]   rx_data,
  input  logic [N_CHAN-1:0]             rx_rdy,
  output logic [N_CHAN-1:0]             rx_enable,
  output logic [N_CHAN*UMF_WIDTH-1:0]   tx_data,
  input  logic [N_CHAN-1:0]             tx_rdy,
  output logic [N_CHAN-1:0]             tx_enable,
  output logic [N_CHAN-1:0]             test_active,
  output logic [N_CHAN-1:0]             test_done,
  output logic [N_CHAN*32-1:0]          stat_beats,
  output logic [N_CHAN*16-1:0]          stat_errors,
  output logic [N_CHAN*32-1:0]          stat_cycles
);

  genvar i;
  generate
    for (i = 0; i < N_CHAN; i++) begin : g_chan
      // Out-of-range channel numbers match no slice and are dropped.
      logic load;
      assign load = cmd_valid && (int'(cmd_chan) == i);

      qa_drv_tester_chan #(
        .UMF_WIDTH (UMF_WIDTH),
        .COUNT_W   (COUNT_W),
        .SEED      (LFSR_SEED ^ 32'(i))
      ) u_chan (
        .clk            (clk),
        .reset          (reset),
        .cmd_load       (load),
        .cmd_mode       (t_TESTER_MODE'(cmd_mode)),
        .cmd_count      (cmd_count),
        .user_en        (user_en[i]),
        .rx_fifo_data   (rx_fifo_data[i*UMF_WIDTH +: UMF_WIDTH]),
        .rx_fifo_rdy    (rx_fifo_rdy[i]),
        .rx_fifo_enable (rx_fifo_enable[i]),
        .tx_fifo_data   (tx_fifo_data[i*UMF_WIDTH +: UMF_WIDTH]),
        .tx_fifo_rdy    (tx_fifo_rdy[i]),
        .tx_fifo_enable (tx_fifo_enable[i]),
        .rx_data        (rx_data[i*UMF_WIDTH +: UMF_WIDTH]),
        .rx_rdy         (rx_rdy[i]),
        .rx_enable      (rx_enable[i]),
        .tx_data        (tx_data[i*UMF_WIDTH +: UMF_WIDTH]),
        .tx_rdy         (tx_rdy[i]),
        .tx_enable      (tx_enable[i]),
        .test_active    (test_active[i]),
        .test_done      (test_done[i]),
        .stat_beats     (stat_beats[i*32 +: 32]),
        .stat_errors    (stat_errors[i*16 +: 16]),
        .stat_cycles    (stat_cycles[i*32 +: 32])
      );
    end
  endgenerate

endmodule

// File: tb/tb_qa_drv_tester_mc.sv
// Bench for qa_drv_tester_mc: randomized traffic against a message-level reference model.
// Latency: n/a.
// Backpressure: rdy lines randomized to exercise stalls.
module tb_qa_drv_tester_mc;

  localparam int          UMF_WIDTH = 128;
  localparam int          N_CHAN    = 2;
  localparam int          COUNT_W   = 31;
  localparam logic [31:0] LFSR_SEED = 32'h1;
  localparam logic [31:0] M_POLY    = 32'h80200003;

  logic clk;
  logic reset;
  logic cmd_valid;
  logic [0:0] cmd_chan;
  logic [1:0] cmd_mode;
  logic [COUNT_W-1:0] cmd_count;
  logic [N_CHAN-1:0] user_en;
  logic [N_CHAN-1:0][UMF_WIDTH-1:0] rx_fifo_data, tx_fifo_data, rx_data, tx_data;
  logic [N_CHAN-1:0] rx_fifo_rdy, rx_fifo_enable, tx_fifo_rdy, tx_fifo_enable;
  logic [N_CHAN-1:0] rx_rdy, rx_enable, tx_rdy, tx_enable;
  logic [N_CHAN-1:0] test_active, test_done;
  logic [N_CHAN-1:0][31:0] stat_beats, stat_cycles;
  logic [N_CHAN-1:0][15:0] stat_errors;

  int n_vec = 0;
  int n_err = 0;

  qa_drv_tester_mc #(
    .UMF_WIDTH (UMF_WIDTH), .N_CHAN (N_CHAN), .COUNT_W (COUNT_W), .LFSR_SEED (LFSR_SEED)
  ) dut (
    .clk (clk), .reset (reset), .cmd_valid (cmd_valid), .cmd_chan (cmd_chan),
    .cmd_mode (cmd_mode), .cmd_count (cmd_count), .user_en (user_en),
    .rx_fifo_data (rx_fifo_data), .rx_fifo_rdy (rx_fifo_rdy), .rx_fifo_enable (rx_fifo_enable),
    .tx_fifo_data (tx_fifo_data), .tx_fifo_rdy (tx_fifo_rdy), .tx_fifo_enable (tx_fifo_enable),
    .rx_data (rx_data), .rx_rdy (rx_rdy), .rx_enable (rx_enable),
    .tx_data (tx_data), .tx_rdy (tx_rdy), .tx_enable (tx_enable),
    .test_active (test_active), .test_done (test_done),
    .stat_beats (stat_beats), .stat_errors (stat_errors), .stat_cycles (stat_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: spec-level LFSR and message construction.
  function automatic logic [31:0] m_step(input logic [31:0] x);
    if (x % 2 == 1) return (x / 2) ^ M_POLY;
    return x / 2;
  endfunction

  function automatic logic [127:0] m_msg(input logic [31:0] l, input int rem, input bit last);
    logic [127:0] m;
    m = {l, l, l, l};
    m[31:1] = 31'(rem);
    m[0] = last;
    return m;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int ch, input logic [1:0] m, input int cnt);
    cmd_valid = 1'b1;
    cmd_chan  = 1'(ch);
    cmd_mode  = m;
    cmd_count = COUNT_W'(cnt);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rand_normal(input int ch);
    rx_data[ch]        = rnd128();
    tx_fifo_data[ch]   = rnd128();
    rx_rdy[ch]         = 1'($urandom_range(0, 1));
    rx_fifo_enable[ch] = 1'($urandom_range(0, 1));
    tx_rdy[ch]         = 1'($urandom_range(0, 1));
    tx_fifo_enable[ch] = 1'($urandom_range(0, 1));
    user_en[ch]        = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_normal(input int ch);
    chk("n_active",  test_active[ch], 0);
    chk("n_rxfdata", rx_fifo_data[ch], rx_data[ch]);
    chk("n_rxfrdy",  rx_fifo_rdy[ch], rx_rdy[ch]);
    chk("n_rxen",    rx_enable[ch], rx_fifo_enable[ch]);
    chk("n_txdata",  tx_data[ch], tx_fifo_data[ch]);
    chk("n_txen",    tx_enable[ch], tx_fifo_enable[ch]);
    chk("n_txfrdy",  tx_fifo_rdy[ch], tx_rdy[ch] & user_en[ch]);
  endtask

  task automatic chk_end(input int ch, input int beats, input int errs, input int cyc);
    chk("end_done",   test_done[ch], 1);
    chk("end_active", test_active[ch], 0);
    chk("end_beats",  stat_beats[ch], 128'(beats));
    chk("end_errors", stat_errors[ch], 128'(errs));
    chk("end_cycles", stat_cycles[ch], 128'(cyc));
    tick();
    chk("end_done_clr", test_done[ch], 0);
  endtask

  task automatic run_source(input int ch, input int cnt);
    logic [31:0] l;
    int rem, beats, cyc, oth;
    bit fin, beat;
    l = LFSR_SEED ^ 32'(ch);
    rem = cnt; beats = 0; cyc = 0; fin = 0; oth = 1 - ch;
    send_cmd(ch, 2'd2, cnt);
    for (int t = 0; t < 400 && !fin; t++) begin
      tx_rdy[ch]         = 1'($urandom_range(0, 1));
      rx_rdy[ch]         = 1'($urandom_range(0, 1));
      tx_fifo_enable[ch] = 1'($urandom_range(0, 1));
      rx_fifo_enable[ch] = 1'($urandom_range(0, 1));
      user_en[ch]        = 1'b1;
      rand_normal(oth);
      #1;
      beat = tx_rdy[ch] && rem != 0;
      chk("src_active", test_active[ch], 1);
      chk("src_txen", tx_enable[ch], beat);
      chk("src_rxen", rx_enable[ch], rx_rdy[ch]);
      chk("src_fifordy", {rx_fifo_rdy[ch], tx_fifo_rdy[ch]}, 0);
      if (beat) chk("src_msg", tx_data[ch], m_msg(l, rem, rem == 1));
      chk_normal(oth);
      tick();
      cyc++;
      if (beat) begin
        rem--; beats++; l = m_step(l);
      end
      if (rem == 0) fin = 1;
    end
    if (!fin) chk("src_timeout", 0, 1);
    chk_end(ch, beats, 0, cyc);
  endtask

  task automatic run_sink(input int ch, input int n, input int bad);
    logic [31:0] l;
    logic [127:0] msg, exp_c;
    int k, beats, errs, cyc, idx;
    bit fin;
    l = LFSR_SEED ^ 32'(ch);
    k = 0; beats = 0; errs = 0; cyc = 0; fin = 0;
    send_cmd(ch, 2'd1, 0);
    for (int t = 0; t < 400 && k < n; t++) begin
      msg = m_msg(l, n - k, k == n - 1);
      if (k == bad) begin
        idx = 32 + int'($urandom_range(0, 31));
        msg[idx] = ~msg[idx];
      end
      rx_data[ch] = msg;
      rx_rdy[ch]  = 1'($urandom_range(0, 1));
      tx_rdy[ch]  = 1'($urandom_range(0, 1));
      #1;
      chk("snk_active", test_active[ch], 1);
      chk("snk_rxen", rx_enable[ch], rx_rdy[ch]);
      chk("snk_txen", tx_enable[ch], 0);
      chk("snk_fifordy", {rx_fifo_rdy[ch], tx_fifo_rdy[ch]}, 0);
      tick();
      cyc++;
      if (rx_rdy[ch]) begin
        if (k == bad) errs++;
        k++; beats++; l = m_step(l);
      end
    end
    if (k < n) chk("snk_timeout", 0, 1);
    exp_c = '0;
    exp_c[47:32] = 16'(errs);
    exp_c[31:0]  = 32'(beats) | 32'h1;
    rx_rdy[ch] = 1'b1;
    for (int t = 0; t < 400 && !fin; t++) begin
      tx_rdy[ch] = 1'($urandom_range(0, 1));
      #1;
      chk("cmpl_active", test_active[ch], 1);
      chk("cmpl_rxen", rx_enable[ch], 0);
      chk("cmpl_txen", tx_enable[ch], tx_rdy[ch]);
      if (tx_rdy[ch]) chk("cmpl_msg", tx_data[ch], exp_c);
      tick();
      cyc++;
      if (tx_rdy[ch]) fin = 1;
    end
    if (!fin) chk("cmpl_timeout", 0, 1);
    chk_end(ch, beats, errs, cyc);
  endtask

  task automatic run_loop(input int ch, input int n);
    logic [127:0] msg;
    int k, beats, cyc;
    bit en;
    k = 0; beats = 0; cyc = 0;
    msg = rnd128();
    msg[0] = (n == 1);
    send_cmd(ch, 2'd3, 0);
    for (int t = 0; t < 400 && k < n; t++) begin
      rx_data[ch] = msg;
      if (t < 3) begin
        rx_rdy[ch] = 1'b1;
        tx_rdy[ch] = 1'b0;
      end else begin
        rx_rdy[ch] = 1'($urandom_range(0, 1));
        tx_rdy[ch] = 1'($urandom_range(0, 1));
      end
      #1;
      en = rx_rdy[ch] & tx_rdy[ch];
      chk("lb_active", test_active[ch], 1);
      chk("lb_rxen", rx_enable[ch], en);
      chk("lb_txen", tx_enable[ch], en);
      chk("lb_data", tx_data[ch], msg);
      tick();
      cyc++;
      if (en) begin
        k++; beats++;
        msg = rnd128();
        msg[0] = (k == n - 1);
      end
    end
    if (k < n) chk("lb_timeout", 0, 1);
    chk_end(ch, beats, 0, cyc);
  endtask

  task automatic chk_idle_stats(input string tag);
    for (int c = 0; c < N_CHAN; c++) begin
      chk({tag, "_active"}, test_active[c], 0);
      chk({tag, "_done"},   test_done[c], 0);
      chk({tag, "_beats"},  stat_beats[c], 0);
      chk({tag, "_errors"}, stat_errors[c], 0);
      chk({tag, "_cycles"}, stat_cycles[c], 0);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_chan = '0; cmd_mode = '0; cmd_count = '0;
    user_en = '0; rx_fifo_enable = '0; tx_fifo_data = '0; tx_fifo_enable = '0;
    rx_data = '0; rx_rdy = '0; tx_rdy = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk_idle_stats("rst");

    // Directed pass-through on channel 0.
    user_en[0] = 1'b1; tx_fifo_data[0] = 128'hA5; tx_rdy[0] = 1'b1;
    #1;
    chk("a5_txdata", tx_data[0], 128'hA5);
    chk("a5_txfrdy_hi", tx_fifo_rdy[0], 1);
    tx_rdy[0] = 1'b0;
    #1;
    chk("a5_txfrdy_lo", tx_fifo_rdy[0], 0);
    tx_rdy[0] = 1'b1; user_en[0] = 1'b0;
    #1;
    chk("a5_user_dis", tx_fifo_rdy[0], 0);
    tick();

    for (int t = 0; t < 20; t++) begin
      rand_normal(0);
      rand_normal(1);
      #1;
      chk_normal(0);
      chk_normal(1);
      tick();
    end

    run_source(1, 4);
    run_source(0, 7);
    run_source(1, 0);
    run_sink(0, 5, -1);
    run_sink(0, 5, 2);
    run_sink(1, 3, 0);
    run_loop(1, 6);

    // Abort mid-SOURCE: no done pulse, stats cleared by the load.
    send_cmd(0, 2'd2, 10);
    tx_rdy[0] = 1'b1;
    tick(); tick(); tick();
    send_cmd(0, 2'd0, 0);
    chk("abort_active", test_active[0], 0);
    chk("abort_done", test_done[0], 0);
    chk("abort_beats", stat_beats[0], 0);
    tick();
    chk("abort_done2", test_done[0], 0);

    // Reset mid-SOURCE.
    send_cmd(0, 2'd2, 10);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_stats("mrst");
    tick();
    chk("mrst_done2", test_done[0], 0);

    run_source(0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
